// File: rtl/l2_mem_responder_pkg.sv
// Shared definitions for the L2 memory responder: global width defaults and
// the data word width used by the responder and its block buffer.
`ifndef BW_WORD_ADDR
`define BW_WORD_ADDR 12
`endif
`ifndef BW_BLOCK
`define BW_BLOCK 2
`endif

package l2_mem_responder_pkg;
  localparam int WORD_W = 32;
endpackage

// File: rtl/l2_mem_block_buffer.sv
// N x 32 staging buffer for one block transfer: one synchronous write port
// and one combinational read port. Contents are not reset.
module l2_mem_block_buffer
  import l2_mem_responder_pkg::*;
#(
  parameter int BW_BLK = `BW_BLOCK
) (
  input  logic              clock_i,
  input  logic              wr_en,
  input  logic [BW_BLK-1:0] wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [BW_BLK-1:0] rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] words [2**BW_BLK];

  // Store one word per cycle at the requested slot.
  always_ff @(posedge clock_i) begin
    if (wr_en) words[wr_idx] <= wr_data;
  end

  assign rd_data = words[rd_idx];

endmodule

// File: rtl/l2_mem_responder.sv
// L2 memory responder: accepts one single-word or block request from the
// cache at a time, fetches/stores the words through a registered word-wide
// memory port and stages them in a block buffer.
module l2_mem_responder
  import l2_mem_responder_pkg::*;
#(
  parameter int BW_ADDR = `BW_WORD_ADDR,
  parameter int BW_BLK  = `BW_BLOCK
) (
  input  logic               clock_i,
  input  logic               resetn_i,
  input  logic               req_i,
  input  logic               req_block_i,
  input  logic               rw_i,
  input  logic [BW_ADDR-1:0] add_i,
  input  logic               write_i,
  input  logic [WORD_W-1:0]  data_i,
  input  logic               read_i,
  output logic               ready_req_o,
  output logic               ready_write_o,
  output logic               ready_read_o,
  output logic [WORD_W-1:0]  data_o,
  output logic               err_o,
  output logic               mem_req_o,
  output logic               mem_rw_o,
  output logic [BW_ADDR-1:0] mem_add_o,
  output logic [WORD_W-1:0]  mem_data_o,
  input  logic               mem_ack_i,
  input  logic [WORD_W-1:0]  mem_data_i
);

  localparam int N  = 2**BW_BLK;
  localparam int CW = BW_BLK + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD      = 2'd1;
  localparam logic [1:0] ST_WR_FILL = 2'd2;
  localparam logic [1:0] ST_WR_MEM  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    RD      = ST_RD,
    WR_FILL = ST_WR_FILL,
    WR_MEM  = ST_WR_MEM
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      len_q, len_d;
  logic [BW_ADDR-1:0] base_q, base_d;
  logic [CW-1:0]      issue_q, issue_d;
  logic [CW-1:0]      fill_q, fill_d;
  logic [CW-1:0]      pop_q, pop_d;
  logic               err_q, err_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_rw_q, mem_rw_d;
  logic [BW_ADDR-1:0] mem_add_q, mem_add_d;
  logic [WORD_W-1:0]  mem_data_q, mem_data_d;

  logic               buf_we;
  logic [BW_BLK-1:0]  buf_wr_idx;
  logic [WORD_W-1:0]  buf_wr_data;
  logic [BW_BLK-1:0]  buf_rd_idx;
  logic [WORD_W-1:0]  buf_rd_data;

  logic               ack_ok;
  logic [CW-1:0]      issue_nx, fill_nx, pop_nx;
  logic [BW_ADDR-1:0] req_base;

  assign ready_req_o   = (state_q == IDLE);
  assign ready_read_o  = (state_q == RD) && (fill_q > pop_q);
  assign ready_write_o = (state_q == WR_FILL) && (fill_q < len_q);
  assign data_o        = buf_rd_data;
  assign err_o         = err_q;
  assign mem_req_o     = mem_req_q;
  assign mem_rw_o      = mem_rw_q;
  assign mem_add_o     = mem_add_q;
  assign mem_data_o    = mem_data_q;

  assign ack_ok   = mem_ack_i && mem_req_q;
  assign issue_nx = issue_q + CW'(1);
  assign fill_nx  = fill_q + CW'(1);
  assign pop_nx   = pop_q + CW'(1);
  assign req_base = req_block_i ? (add_i & ~BW_ADDR'(N - 1)) : add_i;

  // Buffer read slot: the head word for the cache while reading, the next
  // word to hand to memory while writing back, slot 0 when write-back starts.
  always_comb begin
    buf_rd_idx = '0;
    case (state_q)
      RD:      buf_rd_idx = pop_q[BW_BLK-1:0];
      WR_MEM:  buf_rd_idx = issue_nx[BW_BLK-1:0];
      default: buf_rd_idx = '0;
    endcase
  end

  // Next-state, counter, error and memory-port logic; mem_* are loaded one
  // cycle ahead so the port is driven straight from flops.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    base_d      = base_q;
    issue_d     = issue_q;
    fill_d      = fill_q;
    pop_d       = pop_q;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_rw_d    = mem_rw_q;
    mem_add_d   = mem_add_q;
    mem_data_d  = mem_data_q;
    buf_we      = 1'b0;
    buf_wr_idx  = fill_q[BW_BLK-1:0];
    buf_wr_data = data_i;

    // Holding read_i during RD while a fetch is in flight is a normal stall,
    // so only a read outside RD counts as a violation.
    if ((req_i && state_q != IDLE) || (read_i && state_q != RD) ||
        (write_i && !ready_write_o) || (mem_ack_i && !mem_req_q))
      err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          len_d   = req_block_i ? CW'(N) : CW'(1);
          base_d  = req_base;
          issue_d = '0;
          fill_d  = '0;
          pop_d   = '0;
          if (rw_i) begin
            state_d = WR_FILL;
          end else begin
            state_d   = RD;
            mem_req_d = 1'b1;
            mem_rw_d  = 1'b0;
            mem_add_d = req_base;
          end
        end
      end
      RD: begin
        if (ack_ok) begin
          buf_we      = 1'b1;
          buf_wr_idx  = issue_q[BW_BLK-1:0];
          buf_wr_data = mem_data_i;
          issue_d     = issue_nx;
          fill_d      = fill_nx;
          if (issue_nx == len_q) mem_req_d = 1'b0;
          else                   mem_add_d = base_q + BW_ADDR'(issue_nx);
        end
        if (read_i && ready_read_o) begin
          pop_d = pop_nx;
          if (pop_nx == len_q) state_d = IDLE;
        end
      end
      WR_FILL: begin
        if (write_i && ready_write_o) begin
          buf_we = 1'b1;
          fill_d = fill_nx;
          if (fill_nx == len_q) begin
            state_d    = WR_MEM;
            mem_req_d  = 1'b1;
            mem_rw_d   = 1'b1;
            mem_add_d  = base_q;
            mem_data_d = (fill_q == '0) ? data_i : buf_rd_data;
          end
        end
      end
      WR_MEM: begin
        if (ack_ok) begin
          issue_d = issue_nx;
          if (issue_nx == len_q) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            mem_rw_d  = 1'b0;
          end else begin
            mem_add_d  = base_q + BW_ADDR'(issue_nx);
            mem_data_d = buf_rd_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register update; reset aborts any transfer immediately.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      base_q     <= '0;
      issue_q    <= '0;
      fill_q     <= '0;
      pop_q      <= '0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_rw_q   <= 1'b0;
      mem_add_q  <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      base_q     <= base_d;
      issue_q    <= issue_d;
      fill_q     <= fill_d;
      pop_q      <= pop_d;
      err_q      <= err_d;
      mem_req_q  <= mem_req_d;
      mem_rw_q   <= mem_rw_d;
      mem_add_q  <= mem_add_d;
      mem_data_q <= mem_data_d;
    end
  end

  l2_mem_block_buffer #(.BW_BLK(BW_BLK)) u_buffer (
    .clock_i (clock_i),
    .wr_en   (buf_we),
    .wr_idx  (buf_wr_idx),
    .wr_data (buf_wr_data),
    .rd_idx  (buf_rd_idx),
    .rd_data (buf_rd_data)
  );

endmodule

// File: tb/tb_l2_mem_responder.sv
// Testbench for l2_mem_responder: a word-addressed memory model plus
// transaction-level expectations for block/single reads and writes.
module tb_l2_mem_responder;

  localparam int AW    = 12;
  localparam int BB    = 2;
  localparam int N     = 4;
  localparam int MSIZE = 4096;
  localparam int LIMIT = 200;

  logic          clock_i;
  logic          resetn_i;
  logic          req_i;
  logic          req_block_i;
  logic          rw_i;
  logic [AW-1:0] add_i;
  logic          write_i;
  logic [31:0]   data_i;
  logic          read_i;
  logic          ready_req_o;
  logic          ready_write_o;
  logic          ready_read_o;
  logic [31:0]   data_o;
  logic          err_o;
  logic          mem_req_o;
  logic          mem_rw_o;
  logic [AW-1:0] mem_add_o;
  logic [31:0]   mem_data_o;
  logic          mem_ack_i;
  logic [31:0]   mem_data_i;

  logic [31:0] mem_model [MSIZE];
  int          checks;
  int          errors;
  logic        err_exp;

  l2_mem_responder #(.BW_ADDR(AW), .BW_BLK(BB)) dut (
    .clock_i       (clock_i),
    .resetn_i      (resetn_i),
    .req_i         (req_i),
    .req_block_i   (req_block_i),
    .rw_i          (rw_i),
    .add_i         (add_i),
    .write_i       (write_i),
    .data_i        (data_i),
    .read_i        (read_i),
    .ready_req_o   (ready_req_o),
    .ready_write_o (ready_write_o),
    .ready_read_o  (ready_read_o),
    .data_o        (data_o),
    .err_o         (err_o),
    .mem_req_o     (mem_req_o),
    .mem_rw_o      (mem_rw_o),
    .mem_add_o     (mem_add_o),
    .mem_data_o    (mem_data_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s: observed=timeout expected=completion", tag);
  endtask

  task automatic clear_inputs();
    req_i = 0; req_block_i = 0; rw_i = 0; add_i = '0;
    write_i = 0; data_i = '0; read_i = 0;
    mem_ack_i = 0; mem_data_i = '0;
  endtask

  function automatic int base_of(input int addr, input bit blk);
    return blk ? (addr - (addr % N)) : addr;
  endfunction

  // ack_mode: 0 back-to-back, 1 random, 2 stalled 5 cycles
  // read_mode: 0 pop when ready, 1 random pops, 2 read_i held high
  task automatic do_read(input int addr, input bit blk, input int ack_mode,
                         input int read_mode, input bit inject);
    int  len, base, acks, pops, cyc;
    bit  do_ack, rdy;
    len  = blk ? N : 1;
    base = base_of(addr, blk);
    acks = 0; pops = 0; cyc = 0;
    @(negedge clock_i);
    chk("rd_ready_req_idle", 32'(ready_req_o), 32'd1);
    req_i = 1; req_block_i = blk; rw_i = 0; add_i = AW'(addr);
    @(negedge clock_i);
    req_i = 0;
    while (pops < len && cyc < LIMIT) begin
      chk("rd_mem_req", 32'(mem_req_o), 32'(acks < len));
      if (acks < len) begin
        chk("rd_mem_add", 32'(mem_add_o), 32'((base + acks) % MSIZE));
        chk("rd_mem_rw", 32'(mem_rw_o), 32'd0);
      end
      rdy = (pops < acks);
      chk("rd_ready_read", 32'(ready_read_o), 32'(rdy));
      if (rdy) chk("rd_data", data_o, mem_model[(base + pops) % MSIZE]);
      chk("rd_ready_req_busy", 32'(ready_req_o), 32'd0);
      chk("rd_err", 32'(err_o), 32'(err_exp));
      do_ack = 0;
      if (acks < len) begin
        case (ack_mode)
          0:       do_ack = 1;
          1:       do_ack = ($urandom_range(0, 1) == 1);
          default: do_ack = (cyc >= 5);
        endcase
      end
      mem_ack_i  = do_ack;
      mem_data_i = do_ack ? mem_model[(base + acks) % MSIZE] : $urandom;
      case (read_mode)
        0:       read_i = rdy;
        1:       read_i = rdy && ($urandom_range(0, 2) != 0);
        default: read_i = 1;
      endcase
      if (inject && cyc == 1) begin
        req_i = 1; rw_i = 1; req_block_i = 1; add_i = AW'($urandom);
      end
      @(posedge clock_i);
      if (do_ack) acks++;
      if (read_i && rdy) pops++;
      if (req_i) err_exp = 1;
      @(negedge clock_i);
      clear_inputs();
      cyc++;
    end
    if (cyc >= LIMIT) timeout("rd_timeout");
    chk("rd_acks_total", 32'(acks), 32'(len));
    chk("rd_end_ready_req", 32'(ready_req_o), 32'd1);
    chk("rd_end_ready_read", 32'(ready_read_o), 32'd0);
    chk("rd_end_mem_req", 32'(mem_req_o), 32'd0);
    chk("rd_end_err", 32'(err_o), 32'(err_exp));
  endtask

  task automatic do_write(input int addr, input bit blk, input bit gaps);
    int          len, base, pushed, acks, cyc;
    bit          wr, a;
    logic [31:0] wd [N];
    len  = blk ? N : 1;
    base = base_of(addr, blk);
    for (int i = 0; i < N; i++) wd[i] = $urandom;
    pushed = 0; acks = 0; cyc = 0;
    @(negedge clock_i);
    chk("wr_ready_req_idle", 32'(ready_req_o), 32'd1);
    req_i = 1; req_block_i = blk; rw_i = 1; add_i = AW'(addr);
    @(negedge clock_i);
    clear_inputs();
    while (pushed < len && cyc < LIMIT) begin
      chk("wr_ready_write", 32'(ready_write_o), 32'd1);
      chk("wr_fill_mem_req", 32'(mem_req_o), 32'd0);
      wr      = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      write_i = wr;
      data_i  = wr ? wd[pushed] : $urandom;
      @(posedge clock_i);
      if (wr) pushed++;
      @(negedge clock_i);
      clear_inputs();
      cyc++;
    end
    chk("wr_full_ready_write", 32'(ready_write_o), 32'd0);
    while (acks < len && cyc < LIMIT) begin
      chk("wr_mem_req", 32'(mem_req_o), 32'd1);
      chk("wr_mem_rw", 32'(mem_rw_o), 32'd1);
      chk("wr_mem_add", 32'(mem_add_o), 32'((base + acks) % MSIZE));
      chk("wr_mem_data", mem_data_o, wd[acks]);
      chk("wr_ready_req_busy", 32'(ready_req_o), 32'd0);
      a = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      mem_ack_i = a;
      @(posedge clock_i);
      if (a) begin
        mem_model[(base + acks) % MSIZE] = wd[acks];
        acks++;
      end
      @(negedge clock_i);
      clear_inputs();
      cyc++;
    end
    if (cyc >= LIMIT) timeout("wr_timeout");
    chk("wr_end_ready_req", 32'(ready_req_o), 32'd1);
    chk("wr_end_mem_req", 32'(mem_req_o), 32'd0);
    chk("wr_end_err", 32'(err_o), 32'(err_exp));
  endtask

  initial begin
    int a;
    bit b;
    checks = 0; errors = 0; err_exp = 0;
    for (int i = 0; i < MSIZE; i++) mem_model[i] = $urandom;
    clear_inputs();
    resetn_i = 0;
    repeat (2) @(negedge clock_i);
    chk("rst_ready_req", 32'(ready_req_o), 32'd1);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw_o), 32'd0);
    chk("rst_mem_add", 32'(mem_add_o), 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    chk("rst_ready_read", 32'(ready_read_o), 32'd0);
    chk("rst_ready_write", 32'(ready_write_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    resetn_i = 1;

    $display("[TB] block read 0x123, back-to-back acks");
    do_read(32'h123, 1, 0, 0, 0);
    $display("[TB] block write 0x40, then read back");
    do_write(32'h40, 1, 0);
    do_read(32'h40, 1, 1, 1, 0);
    $display("[TB] single read 0x7");
    do_read(32'h7, 0, 0, 0, 0);
    $display("[TB] stalled ack with read_i held high");
    do_read(32'h5, 0, 2, 2, 0);
    do_read(32'h2A1, 1, 2, 2, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, MSIZE - 1);
      b = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) do_write(a, b, 1);
      do_read(a, b, 1, 1, 0);
    end

    $display("[TB] protocol violations");
    @(negedge clock_i);
    read_i = 1;
    @(negedge clock_i);
    read_i = 0;
    err_exp = 1;
    chk("err_read_idle", 32'(err_o), 32'd1);
    do_read(32'h123, 1, 0, 0, 1);
    chk("err_sticky", 32'(err_o), 32'd1);

    $display("[TB] reset after second ack");
    @(negedge clock_i);
    req_i = 1; req_block_i = 1; rw_i = 0; add_i = AW'(32'h200);
    @(negedge clock_i);
    clear_inputs();
    repeat (2) begin
      mem_ack_i  = 1;
      mem_data_i = $urandom;
      @(negedge clock_i);
    end
    mem_ack_i = 0;
    resetn_i  = 0;
    #1;
    err_exp = 0;
    chk("rstmid_mem_req", 32'(mem_req_o), 32'd0);
    chk("rstmid_ready_req", 32'(ready_req_o), 32'd1);
    chk("rstmid_ready_read", 32'(ready_read_o), 32'd0);
    chk("rstmid_err", 32'(err_o), 32'd0);
    @(negedge clock_i);
    resetn_i = 1;
    @(negedge clock_i);
    chk("post_rst_mem_req", 32'(mem_req_o), 32'd0);
    mem_ack_i = 1;
    @(negedge clock_i);
    mem_ack_i = 0;
    err_exp = 1;
    chk("err_stray_ack", 32'(err_o), 32'd1);
    do_read(32'h200, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
